// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one wb_ram slave port among NUM_MASTERS masters.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_ram_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]      wbm_we_i,
    input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
    output logic [NUM_MASTERS*DW-1:0]   wbm_dat_o,
    output logic [NUM_MASTERS-1:0]      wbm_ack_o,
    output logic [NUM_MASTERS-1:0]      wbm_err_o,
    output logic [NUM_MASTERS-1:0]      wbm_rty_o,
    output logic [AW-1:0]               wbs_adr_o,
    output logic [DW-1:0]               wbs_dat_o,
    output logic [DW/8-1:0]             wbs_sel_o,
    output logic                        wbs_we_o,
    output logic                        wbs_cyc_o,
    output logic                        wbs_stb_o,
    output logic [2:0]                  wbs_cti_o,
    output logic [1:0]                  wbs_bte_o,
    input  logic [DW-1:0]               wbs_dat_i,
    input  logic                        wbs_ack_i,
    input  logic                        wbs_err_i,
    input  logic                        wbs_rty_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);
    localparam int SW = DW / 8;
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          last_q, last_d;
    logic [NUM_MASTERS-1:0] req;
    logic [IW-1:0]          winner;
    logic                   found;
    logic                   own_cyc, own_stb;
    logic                   timeout;
    logic                   resp;

    assign resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] blk_q, blk_d;

    assign timeout = (state_q == OWNED) && (cnt_q == CW'(TIMEOUT_CYCLES));
    // A timed-out master stays excluded until it lets go of cyc.
    assign req     = wbm_cyc_i & ~blk_q;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != OWNED || resp)
            cnt_d = '0;
        else if (own_cyc && own_stb)
            cnt_d = cnt_q + CW'(1);
        blk_d = (blk_q & wbm_cyc_i) | (timeout ? grant_q : '0);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt_q <= '0;
            blk_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            blk_q <= blk_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign req     = wbm_cyc_i;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Rotating search: masters above the last owner first, then wrap around.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i] && i > int'(last_q)) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i] && i <= int'(last_q)) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end

        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWNED;
                    last_d  = winner;
                    for (int i = 0; i < NUM_MASTERS; i++)
                        grant_d[i] = (i == int'(winner));
                end
            end
            OWNED: begin
                if (!own_cyc || timeout) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // AND-OR mux on the one-hot grant; everything reads as zero while idle.
    always_comb begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                own_cyc   = own_cyc   | wbm_cyc_i[i];
                own_stb   = own_stb   | wbm_stb_i[i];
                wbs_adr_o = wbs_adr_o | wbm_adr_i[i*AW +: AW];
                wbs_dat_o = wbs_dat_o | wbm_dat_i[i*DW +: DW];
                wbs_sel_o = wbs_sel_o | wbm_sel_i[i*SW +: SW];
                wbs_we_o  = wbs_we_o  | wbm_we_i[i];
                wbs_cti_o = wbs_cti_o | wbm_cti_i[i*3 +: 3];
                wbs_bte_o = wbs_bte_o | wbm_bte_i[i*2 +: 2];
            end
        end
        wbs_cyc_o = own_cyc & ~timeout;
        wbs_stb_o = own_cyc & own_stb & ~timeout;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
            assign wbm_dat_o[gi*DW +: DW] = wbs_dat_i;
            assign wbm_ack_o[gi] = grant_q[gi] & wbs_ack_i;
            assign wbm_err_o[gi] = grant_q[gi] & (wbs_err_i | timeout);
            assign wbm_rty_o[gi] = grant_q[gi] & wbs_rty_i;
        end
    endgenerate

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Self-checking bench for wb_ram_arbiter: two masters, a registered-ack RAM stub,
// directed vector table plus contention, burst, reset and watchdog sequences.
module tb_wb_ram_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 256;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*AW-1:0] wbm_adr = '0;
    logic [N*DW-1:0] wbm_dat = '0;
    logic [N*SW-1:0] wbm_sel = '0;
    logic [N-1:0]    wbm_we = '0, wbm_cyc = '0, wbm_stb = '0;
    logic [N*3-1:0]  wbm_cti = '0;
    logic [N*2-1:0]  wbm_bte = '0;
    logic [N*DW-1:0] wbm_dat_o;
    logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o;
    logic [SW-1:0]   wbs_sel_o;
    logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [2:0]      wbs_cti_o;
    logic [1:0]      wbs_bte_o;
    logic [DW-1:0]   wbs_dat_i;
    logic            wbs_ack_i;
    logic [N-1:0]    grant_o;

    wb_ram_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TB_TO)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbm_adr_i(wbm_adr), .wbm_dat_i(wbm_dat), .wbm_sel_i(wbm_sel),
        .wbm_we_i(wbm_we), .wbm_cyc_i(wbm_cyc), .wbm_stb_i(wbm_stb),
        .wbm_cti_i(wbm_cti), .wbm_bte_i(wbm_bte),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
        .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(1'b0), .wbs_rty_i(1'b0),
        .grant_o(grant_o)
    );

    // RAM stub: registered ack, one beat per two cycles.
    logic [31:0] mem [256];
    logic        ack_q;
    logic [31:0] rdat_q;
    logic        stub_noack = 1'b0;
    assign wbs_ack_i = ack_q;
    assign wbs_dat_i = rdat_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            rdat_q <= '0;
        end else if (wbs_cyc_o && wbs_stb_o && !ack_q && !stub_noack) begin
            ack_q  <= 1'b1;
            rdat_q <= mem[wbs_adr_o[9:2]];
            if (wbs_we_o)
                for (int b = 0; b < SW; b++)
                    if (wbs_sel_o[b]) mem[wbs_adr_o[9:2]][b*8 +: 8] <= wbs_dat_o[b*8 +: 8];
        end else begin
            ack_q <= 1'b0;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic raise(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti);
        wbm_cyc[m] = 1'b1;
        wbm_stb[m] = 1'b1;
        wbm_we[m]  = we;
        wbm_adr[m*AW +: AW] = adr;
        wbm_dat[m*DW +: DW] = dat;
        wbm_sel[m*SW +: SW] = sel;
        wbm_cti[m*3 +: 3]   = cti;
        wbm_bte[m*2 +: 2]   = 2'b00;
    endtask

    task automatic drop(input int m);
        wbm_cyc[m] = 1'b0;
        wbm_stb[m] = 1'b0;
        wbm_we[m]  = 1'b0;
    endtask

    task automatic wait_grant(input logic [1:0] g, input string name);
        for (int k = 0; k < 30 && grant_o !== g; k++) @(negedge clk);
        chk(name, 32'(grant_o), 32'(g));
    endtask

    task automatic wait_ack(input int m, input string name, output logic [31:0] rd);
        for (int k = 0; k < 30 && wbm_ack_o[m] !== 1'b1; k++) @(negedge clk);
        chk(name, 32'(wbm_ack_o[m]), 32'd1);
        rd = wbm_dat_o[m*DW +: DW];
        $display("txn %s: master %0d ack, data %h", name, m, rd);
    endtask

    task automatic pulse_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [1:0]  exp_grant;
        logic [31:0] exp_rdat;
    } vec_t;
    vec_t vecs[7];

    task automatic run_vec(input int i);
        logic        oth;
        logic [31:0] rd;
        oth = 1'b0;
        rd  = '0;
        @(negedge clk) raise(vecs[i].m, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 3'b000);
        @(negedge clk) chk($sformatf("v%0d_grant", i), 32'(grant_o), 32'(vecs[i].exp_grant));
        for (int k = 0; k < 30; k++) begin
            if (wbm_ack_o[1 - vecs[i].m]) oth = 1'b1;
            if (wbm_ack_o[vecs[i].m]) break;
            @(negedge clk);
        end
        chk($sformatf("v%0d_ack", i), 32'(wbm_ack_o[vecs[i].m]), 32'd1);
        rd = wbm_dat_o[vecs[i].m*DW +: DW];
        drop(vecs[i].m);
        if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdat);
        chk($sformatf("v%0d_other_ack", i), 32'(oth), 32'd0);
        @(negedge clk) chk($sformatf("v%0d_release", i), 32'(grant_o), 32'd0);
        $display("vec %0d: m%0d we=%0b adr=%h dat=%h rd=%h", i, vecs[i].m, vecs[i].we, vecs[i].adr, vecs[i].dat, rd);
    endtask

    logic [1:0] gtrace[$];
    int         acks[2];

    // Each master re-raises cyc the cycle after it drops it, until its beats are used up.
    task automatic contend(input int b0, input int b1);
        int         rem[2];
        logic [1:0] prev;
        rem[0] = b0; rem[1] = b1;
        acks[0] = 0; acks[1] = 0;
        gtrace.delete();
        prev = 2'b00;
        @(negedge clk);
        if (rem[0] > 0) raise(0, 1'b0, 32'h40, 32'h0, 4'hF, 3'b000);
        if (rem[1] > 0) raise(1, 1'b0, 32'h44, 32'h0, 4'hF, 3'b000);
        for (int c = 0; c < 300 && (rem[0] > 0 || rem[1] > 0 || grant_o != 2'b00); c++) begin
            @(negedge clk);
            if (grant_o != prev) begin
                gtrace.push_back(grant_o);
                prev = grant_o;
            end
            for (int m = 0; m < 2; m++) begin
                if (wbm_cyc[m] && wbm_ack_o[m]) begin
                    drop(m);
                    rem[m]--;
                    acks[m]++;
                end else if (!wbm_cyc[m] && rem[m] > 0) begin
                    raise(m, 1'b0, 32'h40 + 32'(m * 4), 32'h0, 4'hF, 3'b000);
                end
            end
        end
        chk("contend_done", 32'(rem[0] + rem[1]), 32'd0);
        $display("contend %0d/%0d: acks %0d/%0d, %0d grant changes", b0, b1, acks[0], acks[1], gtrace.size());
    endtask

    initial begin
        logic [31:0] rd;
        int          beats, bad, errs, first;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        vecs[0] = '{0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 2'b01, 32'h0};
        vecs[1] = '{0, 1'b0, 32'h14, 32'h0,        4'hF, 2'b01, 32'hDEADBEEF};
        vecs[2] = '{1, 1'b1, 32'h1C, 32'h12345678, 4'hF, 2'b10, 32'h0};
        vecs[3] = '{1, 1'b0, 32'h14, 32'h0,        4'hF, 2'b10, 32'hDEADBEEF};
        vecs[4] = '{0, 1'b0, 32'h1C, 32'h0,        4'hF, 2'b01, 32'h12345678};
        vecs[5] = '{1, 1'b1, 32'h14, 32'hAAAA5555, 4'h3, 2'b10, 32'h0};
        vecs[6] = '{0, 1'b0, 32'h14, 32'h0,        4'hF, 2'b01, 32'hDEAD5555};

        #12;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_cyc", 32'(wbs_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbs_stb_o), 32'd0);
        chk("rst_ack", 32'(wbm_ack_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Simultaneous request after reset: master 0 first, one idle cycle, then master 1.
        pulse_reset();
        contend(1, 1);
        chk("sim_len", 32'(gtrace.size()), 32'd4);
        if (gtrace.size() == 4) begin
            chk("sim_g0", 32'(gtrace[0]), 32'h1);
            chk("sim_g1", 32'(gtrace[1]), 32'h0);
            chk("sim_g2", 32'(gtrace[2]), 32'h2);
            chk("sim_g3", 32'(gtrace[3]), 32'h0);
        end

        // Continuous contention: strict alternation starting with master 0.
        contend(4, 4);
        chk("alt_acks0", 32'(acks[0]), 32'd4);
        chk("alt_acks1", 32'(acks[1]), 32'd4);
        chk("alt_len", 32'(gtrace.size()), 32'd16);
        bad = 0;
        for (int i = 0; i < gtrace.size(); i++) begin
            if (i % 2 == 1) begin
                if (gtrace[i] != 2'b00) bad++;
            end else if (gtrace[i] != (((i / 2) % 2 == 0) ? 2'b01 : 2'b10)) begin
                bad++;
            end
        end
        chk("alt_order", 32'(bad), 32'd0);

        // Master 1 burst with master 0 waiting.
        @(negedge clk) raise(1, 1'b1, 32'(16 * 4), 32'hB0, 4'hF, 3'b010);
        @(negedge clk) chk("burst_grant", 32'(grant_o), 32'h2);
        raise(0, 1'b0, 32'(17 * 4), 32'h0, 4'hF, 3'b000);
        beats = 0;
        bad = 0;
        for (int k = 0; k < 60 && beats < 4; k++) begin
            @(negedge clk);
            if (grant_o !== 2'b10) bad++;
            if (wbm_ack_o[0]) bad++;
            if (wbm_ack_o[1]) begin
                beats++;
                if (beats == 4) drop(1);
                else raise(1, 1'b1, 32'((16 + beats) * 4), 32'hB0 + 32'(beats), 4'hF,
                           (beats == 3) ? 3'b111 : 3'b010);
            end
        end
        chk("burst_beats", 32'(beats), 32'd4);
        chk("burst_hold", 32'(bad), 32'd0);
        @(negedge clk) chk("burst_gap", 32'(grant_o), 32'h0);
        @(negedge clk) chk("burst_next", 32'(grant_o), 32'h1);
        wait_ack(0, "burst_m0", rd);
        chk("burst_rdata", rd, 32'hB1);
        drop(0);
        wait_grant(2'b00, "burst_release");

        // Reset in the middle of a master 0 burst.
        @(negedge clk) raise(0, 1'b1, 32'(24 * 4), 32'hC0, 4'hF, 3'b010);
        @(negedge clk) chk("rb_grant", 32'(grant_o), 32'h1);
        wait_ack(0, "rb_beat0", rd);
        raise(0, 1'b1, 32'(25 * 4), 32'hC1, 4'hF, 3'b010);
        @(negedge clk) chk("rb_cyc_before", 32'(wbs_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_cyc", 32'(wbs_cyc_o), 32'd0);
        chk("rb_stb", 32'(wbs_stb_o), 32'd0);
        chk("rb_adr", wbs_adr_o, 32'd0);
        chk("rb_we", 32'(wbs_we_o), 32'd0);
        chk("rb_grant0", 32'(grant_o), 32'd0);
        chk("rb_ack", 32'(wbm_ack_o), 32'd0);
        drop(0);
        @(negedge clk) rst_n = 1'b1;
        raise(0, 1'b0, 32'(24 * 4), 32'h0, 4'hF, 3'b000);
        raise(1, 1'b0, 32'(25 * 4), 32'h0, 4'hF, 3'b000);
        @(negedge clk) chk("rb_prio", 32'(grant_o), 32'h1);
        wait_ack(0, "rb_m0", rd);
        chk("rb_rdata", rd, 32'hC0);
        drop(0);
        wait_grant(2'b10, "rb_m1_grant");
        wait_ack(1, "rb_m1", rd);
        drop(1);
        wait_grant(2'b00, "rb_release");

`ifdef WB_ARB_TIMEOUT_EN
        stub_noack = 1'b1;
        @(negedge clk) raise(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000);
        @(negedge clk) chk("to_grant", 32'(grant_o), 32'h1);
        errs = 0;
        first = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (wbm_err_o[0]) begin
                errs++;
                if (first < 0) first = c;
                chk("to_cyc_forced", 32'(wbs_cyc_o), 32'd0);
            end
        end
        chk("to_err_count", 32'(errs), 32'd1);
        chk("to_err_cycle", 32'(first), 32'd16);
        chk("to_blocked", 32'(grant_o), 32'd0);
        drop(0);
        stub_noack = 1'b0;
        @(negedge clk) raise(0, 1'b0, 32'h0, 32'h0, 4'hF, 3'b000);
        wait_grant(2'b01, "to_regrant");
        wait_ack(0, "to_after", rd);
        drop(0);
        wait_grant(2'b00, "to_release");
`else
        errs = 0;
        first = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
